// File: rtl/if_fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: reset level, zero word,
// bus widths and the fetch FSM state encoding.
package if_fetch_unit_pkg;
    localparam logic        ResetEnable     = 1'b1;
    localparam logic [31:0] ZeroWord        = 32'h0000_0000;
    localparam int          AddressBusWidth = 32;
    localparam int          DataBusWidth    = 32;

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_FETCH   = 2'd1;
    localparam logic [1:0] STATE_HOLD    = 2'd2;
    localparam logic [1:0] STATE_DISCARD = 2'd3;
endpackage

// File: rtl/if_fetch_unit_hold_buffer.sv
// One-entry pc/instruction hold buffer (if_hold_buffer) used while the
// downstream stage is stalled; clear wins over load.
module if_fetch_unit_hold_buffer
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = AddressBusWidth,
    parameter int DATA_WIDTH = DataBusWidth
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    input  logic [DATA_WIDTH-1:0] load_instruction,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instruction
);
    always_ff @(posedge clock) begin
        if (reset == ResetEnable || clear) begin
            full        <= 1'b0;
            pc          <= '0;
            instruction <= '0;
        end else if (load) begin
            full        <= 1'b1;
            pc          <= load_pc;
            instruction <= load_instruction;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: pc ownership, one-outstanding imem requests, stall
// hold buffer and branch redirect. Optional macro: FETCH_MISALIGN_CHECK_EN.
//
// state   | meaning
// IDLE    | no request; moves to FETCH next cycle unless halted on a misaligned target
// FETCH   | requesting imem at pc
// HOLD    | fetched word parked in hold buffer while downstream stalls
// DISCARD | waiting out a stale in-flight request whose data will be dropped
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = AddressBusWidth,
    parameter int                    DATA_WIDTH = DataBusWidth,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall_in,
    input  logic                  branch_flag_in,
    input  logic [ADDR_WIDTH-1:0] branch_target_in,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0] if_program_counter,
    output logic [DATA_WIDTH-1:0] if_instruction,
    output logic                  if_valid,
    output logic                  if_misaligned
);
    localparam logic [DATA_WIDTH-1:0] ZERO_INSTR = DATA_WIDTH'(ZeroWord);
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] stale_addr;
    logic                  bad_target;
    logic                  halted;
    logic                  hold_load;
    logic                  hold_clear;
    logic                  hold_full;
    logic [ADDR_WIDTH-1:0] hold_pc;
    logic [DATA_WIDTH-1:0] hold_instruction;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign bad_target = branch_target_in[1:0] != 2'b00;

    always_ff @(posedge clock) begin
        if (reset == ResetEnable)
            halted <= 1'b0;
        else if (branch_flag_in)
            halted <= bad_target;
    end
`else
    assign bad_target = 1'b0;
    assign halted     = 1'b0;
`endif

    assign if_misaligned = halted;
    assign imem_req      = (state == STATE_FETCH) || (state == STATE_DISCARD);
    assign imem_addr     = (state == STATE_DISCARD) ? stale_addr : pc;

    assign hold_load  = (reset != ResetEnable) && !branch_flag_in &&
                        (state == STATE_FETCH) && imem_ready && stall_in;
    assign hold_clear = branch_flag_in || ((state == STATE_HOLD) && !stall_in);

    if_fetch_unit_hold_buffer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_hold_buffer (
        .clock           (clock),
        .reset           (reset),
        .load            (hold_load),
        .clear           (hold_clear),
        .load_pc         (pc),
        .load_instruction(imem_rdata),
        .full            (hold_full),
        .pc              (hold_pc),
        .instruction     (hold_instruction)
    );

    always_ff @(posedge clock) begin
        if (reset == ResetEnable) begin
            state              <= STATE_IDLE;
            pc                 <= RESET_PC;
            stale_addr         <= '0;
            if_program_counter <= '0;
            if_instruction     <= ZERO_INSTR;
            if_valid           <= 1'b0;
        end else if (branch_flag_in) begin
            pc             <= branch_target_in;
            if_valid       <= 1'b0;
            if_instruction <= ZERO_INSTR;
            if (bad_target) begin
                state <= STATE_IDLE;
            end else if (state == STATE_DISCARD) begin
                state <= imem_ready ? STATE_FETCH : STATE_DISCARD;
            end else if (state == STATE_FETCH && !imem_ready) begin
                // The memory still owes a response for the old address.
                state      <= STATE_DISCARD;
                stale_addr <= pc;
            end else begin
                state <= STATE_FETCH;
            end
        end else begin
            case (state)
                STATE_IDLE: begin
                    state <= halted ? STATE_IDLE : STATE_FETCH;
                    if (!stall_in) begin
                        if_valid       <= 1'b0;
                        if_instruction <= ZERO_INSTR;
                    end
                end
                STATE_FETCH: begin
                    if (imem_ready) begin
                        pc <= pc + STEP;
                        if (stall_in) begin
                            state <= STATE_HOLD;
                        end else begin
                            if_program_counter <= pc;
                            if_instruction     <= imem_rdata;
                            if_valid           <= 1'b1;
                        end
                    end else if (!stall_in) begin
                        if_valid       <= 1'b0;
                        if_instruction <= ZERO_INSTR;
                    end
                end
                STATE_HOLD: begin
                    if (!stall_in) begin
                        if_program_counter <= hold_pc;
                        if_instruction     <= hold_instruction;
                        if_valid           <= hold_full;
                        state              <= STATE_FETCH;
                    end
                end
                STATE_DISCARD: begin
                    if (imem_ready)
                        state <= STATE_FETCH;
                    if (!stall_in) begin
                        if_valid       <= 1'b0;
                        if_instruction <= ZERO_INSTR;
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit; the misaligned-target test
// follows FETCH_MISALIGN_CHECK_EN.
module tb_if_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall_in = 1'b0;
    logic        branch_flag_in = 1'b0;
    logic [31:0] branch_target_in = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] if_program_counter;
    logic [31:0] if_instruction;
    logic        if_valid;
    logic        if_misaligned;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h8) ? 32'hDEAD_BEEF : (32'h1300_0000 | a);
    endfunction

    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hBAD0_0000;

    if_fetch_unit dut (
        .clock             (clock),
        .reset             (reset),
        .stall_in          (stall_in),
        .branch_flag_in    (branch_flag_in),
        .branch_target_in  (branch_target_in),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .if_program_counter(if_program_counter),
        .if_instruction    (if_instruction),
        .if_valid          (if_valid),
        .if_misaligned     (if_misaligned)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves the DUT in its first FETCH cycle, requesting RESET_PC.
    task automatic do_reset(input logic rdy);
        reset = 1'b1; stall_in = 1'b0; branch_flag_in = 1'b0; imem_ready = rdy;
        step(); step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b1; stall_in = 1'b0; branch_flag_in = 1'b0;
        step(); step(); step();
        total++;
        if (if_valid !== 1'b0 || if_misaligned !== 1'b0 || imem_req !== 1'b0 ||
            if_program_counter !== 32'h0 || if_instruction !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: valid=%b mis=%b req=%b pc=%h instr=%h, need all 0",
                     if_valid, if_misaligned, imem_req, if_program_counter, if_instruction);
        end
        reset = 1'b0;
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL first_req: req=%b addr=%h, need 1 00000000", imem_req, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (if_valid !== 1'b1 || if_program_counter !== 32'(4 * i) ||
                if_instruction !== mem_word(32'(4 * i))) begin
                bad++;
                $display("FAIL back_to_back[%0d]: valid=%b pc=%h instr=%h, need 1 %h %h", i,
                         if_valid, if_program_counter, if_instruction, 32'(4 * i), mem_word(32'(4 * i)));
            end
        end
    endtask

    task automatic test_wait_latency();
        logic [31:0] prev_pc;
        logic [31:0] a;
        do_reset(1'b0);
        prev_pc = 32'h0;
        for (int n = 0; n < 2; n++) begin
            a = 32'(4 * n);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== a) begin
                    bad++;
                    $display("FAIL wait_addr[%0d.%0d]: req=%b addr=%h, need 1 %h", n, k, imem_req, imem_addr, a);
                end
                step();
                total++;
                if (if_valid !== 1'b0 || if_instruction !== 32'h0 || if_program_counter !== prev_pc) begin
                    bad++;
                    $display("FAIL wait_bubble[%0d.%0d]: valid=%b instr=%h pc=%h, need 0 0 %h",
                             n, k, if_valid, if_instruction, if_program_counter, prev_pc);
                end
            end
            imem_ready = 1'b1;
            step();
            imem_ready = 1'b0;
            total++;
            if (if_valid !== 1'b1 || if_program_counter !== a || if_instruction !== mem_word(a)) begin
                bad++;
                $display("FAIL wait_data[%0d]: valid=%b pc=%h instr=%h, need 1 %h %h",
                         n, if_valid, if_program_counter, if_instruction, a, mem_word(a));
            end
            prev_pc = a;
        end
    endtask

    task automatic test_stall_hold();
        do_reset(1'b1);
        step(); step();
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_program_counter !== 32'h4 ||
                if_instruction !== mem_word(32'h4)) begin
                bad++;
                $display("FAIL stall_frozen[%0d]: req=%b valid=%b pc=%h instr=%h, need 0 1 00000004 %h",
                         k, imem_req, if_valid, if_program_counter, if_instruction, mem_word(32'h4));
            end
        end
        stall_in = 1'b0;
        step();
        total++;
        if (if_valid !== 1'b1 || if_program_counter !== 32'h8 || if_instruction !== 32'hDEAD_BEEF ||
            imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            bad++;
            $display("FAIL stall_release: valid=%b pc=%h instr=%h req=%b addr=%h, need 1 8 deadbeef 1 c",
                     if_valid, if_program_counter, if_instruction, imem_req, imem_addr);
        end
        step();
        total++;
        if (if_valid !== 1'b1 || if_program_counter !== 32'hC) begin
            bad++;
            $display("FAIL stall_next: valid=%b pc=%h, need 1 0000000c", if_valid, if_program_counter);
        end
    endtask

    task automatic test_branch_discard();
        do_reset(1'b1);
        step(); step(); step(); step();
        imem_ready = 1'b0;
        step();
        branch_flag_in = 1'b1; branch_target_in = 32'h100;
        step();
        branch_flag_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_valid !== 1'b0) begin
                bad++;
                $display("FAIL discard_wait[%0d]: req=%b addr=%h valid=%b, need 1 00000010 0",
                         k, imem_req, imem_addr, if_valid);
            end
            step();
        end
        imem_ready = 1'b1;
        total++;
        if (imem_addr !== 32'h10) begin
            bad++;
            $display("FAIL discard_ack_addr: addr=%h, need 00000010", imem_addr);
        end
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL discard_drop: req=%b addr=%h valid=%b, need 1 00000100 0", imem_req, imem_addr, if_valid);
        end
        step();
        total++;
        if (if_valid !== 1'b1 || if_program_counter !== 32'h100 || if_instruction !== mem_word(32'h100)) begin
            bad++;
            $display("FAIL discard_target: valid=%b pc=%h instr=%h, need 1 00000100 %h",
                     if_valid, if_program_counter, if_instruction, mem_word(32'h100));
        end
    endtask

    task automatic test_branch_stall();
        do_reset(1'b1);
        step();
        stall_in = 1'b1;
        step();
        total++;
        if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_program_counter !== 32'h0) begin
            bad++;
            $display("FAIL bstall_hold: req=%b valid=%b pc=%h, need 0 1 0", imem_req, if_valid, if_program_counter);
        end
        branch_flag_in = 1'b1; branch_target_in = 32'h100;
        step();
        branch_flag_in = 1'b0;
        total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL bstall_flush: valid=%b req=%b addr=%h, need 0 1 00000100", if_valid, imem_req, imem_addr);
        end
        step();
        total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL bstall_still: valid=%b req=%b, need 0 0", if_valid, imem_req);
        end
        stall_in = 1'b0;
        step();
        total++;
        if (if_valid !== 1'b1 || if_program_counter !== 32'h100 || if_instruction !== mem_word(32'h100)) begin
            bad++;
            $display("FAIL bstall_first: valid=%b pc=%h instr=%h, need 1 00000100 %h",
                     if_valid, if_program_counter, if_instruction, mem_word(32'h100));
        end
    endtask

    task automatic test_pc_wrap();
        do_reset(1'b1);
        step();
        branch_flag_in = 1'b1; branch_target_in = 32'hFFFF_FFFC;
        step();
        branch_flag_in = 1'b0;
        total++;
        if (if_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_branch: valid=%b addr=%h, need 0 fffffffc", if_valid, imem_addr);
        end
        step();
        total++;
        if (if_valid !== 1'b1 || if_program_counter !== 32'hFFFF_FFFC || imem_req !== 1'b1 ||
            imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL wrap_next: valid=%b pc=%h req=%b addr=%h, need 1 fffffffc 1 0",
                     if_valid, if_program_counter, imem_req, imem_addr);
        end
    endtask

    task automatic test_misalign();
        do_reset(1'b1);
        step();
        branch_flag_in = 1'b1; branch_target_in = 32'h102;
        step();
        branch_flag_in = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        step(); step();
        total++;
        if (if_misaligned !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL misalign_halt: mis=%b req=%b valid=%b, need 1 0 0", if_misaligned, imem_req, if_valid);
        end
        branch_flag_in = 1'b1; branch_target_in = 32'h200;
        step();
        branch_flag_in = 1'b0;
        total++;
        if (if_misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            bad++;
            $display("FAIL misalign_clear: mis=%b req=%b addr=%h, need 0 1 00000200", if_misaligned, imem_req, imem_addr);
        end
        step();
        total++;
        if (if_valid !== 1'b1 || if_program_counter !== 32'h200) begin
            bad++;
            $display("FAIL misalign_resume: valid=%b pc=%h, need 1 00000200", if_valid, if_program_counter);
        end
`else
        total++;
        if (if_misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h102) begin
            bad++;
            $display("FAIL misalign_off: mis=%b req=%b addr=%h, need 0 1 00000102", if_misaligned, imem_req, imem_addr);
        end
        step();
        total++;
        if (if_valid !== 1'b1 || if_program_counter !== 32'h102 || if_instruction !== mem_word(32'h102)) begin
            bad++;
            $display("FAIL misalign_off_data: valid=%b pc=%h instr=%h, need 1 00000102 %h",
                     if_valid, if_program_counter, if_instruction, mem_word(32'h102));
        end
`endif
    endtask

    initial begin
        test_reset();
        test_wait_latency();
        test_stall_hold();
        test_branch_discard();
        test_branch_stall();
        test_pc_wrap();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
